// File: rtl/xadac_vdot.sv
// -----------------------------------------------------------------------------
// xadac_pkg / xadac_vdot
//
// Two-stage pipelined 8-bit dot-product unit for the xadac vector accelerator.
// Sits between VRF operand read and scalar writeback to the core.
//
//   Stage 1 (MUL): 16 lane products ext(vs1_k) * ext(vs2_k), lanes at or
//                  beyond the active length forced to zero; id and acc ride
//                  along.
//   Stage 2 (ADD): adder tree over the 16 products, sign-extended to 32 bits
//                  and added to acc (wraps modulo 2^32).
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_valid_i / in_ready_o       operand bundle handshake
//   in_id_i                       scoreboard tag, passed through unchecked
//   in_vs1_i, in_vs2_i            128-bit operands, lane k = bits [8k+7:8k]
//   in_acc_i                      initial accumulator
//   in_vlen_i                     active lane count (0 = none, >=16 = all)
//   in_signed_i                   1 = signed int8 lanes, 0 = unsigned
//   out_valid_o / out_ready_i     result handshake
//   out_id_o, out_sum_o           tag and accumulated dot product
// -----------------------------------------------------------------------------
package xadac_pkg;
  localparam int VectorWidth = 128;
  localparam int ElemWidth   = 8;
  localparam int Lanes       = VectorWidth / ElemWidth;
  localparam int SumWidth    = 32;
  localparam int IdWidth     = 4;
  localparam int VLenWidth   = 7;
  // 9-bit x 9-bit signed product; the operand ranges always fit in 17 bits.
  localparam int ProdWidth   = 17;
  // 16 products of 17 bits need 4 extra bits of headroom.
  localparam int TreeWidth   = ProdWidth + 4;

  typedef logic [VectorWidth-1:0]      VectorT;
  typedef logic [ElemWidth-1:0]        ElemT;
  typedef logic [SumWidth-1:0]         SumT;
  typedef logic [IdWidth-1:0]          IdT;
  typedef logic [VLenWidth-1:0]        VLenT;
  typedef logic signed [ProdWidth-1:0] ProdT;
  typedef logic signed [TreeWidth-1:0] TreeT;
endpackage

module xadac_vdot
  import xadac_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [IdWidth-1:0]     in_id_i,
  input  logic [VectorWidth-1:0] in_vs1_i,
  input  logic [VectorWidth-1:0] in_vs2_i,
  input  logic [SumWidth-1:0]    in_acc_i,
  input  logic [VLenWidth-1:0]   in_vlen_i,
  input  logic                   in_signed_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [IdWidth-1:0]     out_id_o,
  output logic [SumWidth-1:0]    out_sum_o
);

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic s1_v_q, s1_v_d;
  logic s2_v_q, s2_v_d;
  logic adv1, adv2;

  // in_ready_o depends on out_ready_i through a single AND/OR level and never
  // on in_valid_i, so upstream can compute valid from ready without a loop.
  always_comb begin
    adv2       = s1_v_q && (!s2_v_q || out_ready_i);
    in_ready_o = !s1_v_q || adv2;
    adv1       = in_valid_i && in_ready_o;

    // Stage 1 fills on accept, empties when it hands over without a refill.
    s1_v_d = s1_v_q;
    if (adv1)      s1_v_d = 1'b1;
    else if (adv2) s1_v_d = 1'b0;

    // Stage 2 fills on hand-over, empties when the consumer drains it.
    s2_v_d = s2_v_q;
    if (adv2)             s2_v_d = 1'b1;
    else if (out_ready_i) s2_v_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: lane products
  // ---------------------------------------------------------------------------
  ProdT prod_q [Lanes];
  ProdT prod_d [Lanes];
  IdT   s1_id_q, s1_id_d;
  SumT  s1_acc_q, s1_acc_d;

  always_comb begin
    logic signed [ElemWidth:0]     a_x;
    logic signed [ElemWidth:0]     b_x;
    logic signed [2*ElemWidth+1:0] p_full;
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    a_x      = '0;
    b_x      = '0;
    p_full   = '0;
    s1_id_d  = in_id_i;
    s1_acc_d = in_acc_i;
    for (int k = 0; k < Lanes; k++) begin
      // Unsigned lanes get a 0 guard bit, signed lanes replicate their MSB.
      a_x    = {in_signed_i & in_vs1_i[k*ElemWidth+ElemWidth-1], in_vs1_i[k*ElemWidth +: ElemWidth]};
      b_x    = {in_signed_i & in_vs2_i[k*ElemWidth+ElemWidth-1], in_vs2_i[k*ElemWidth +: ElemWidth]};
      p_full = a_x * b_x;
      // vlen >= Lanes activates every lane; vlen = 0 activates none.
      prod_d[k] = (in_vlen_i > VLenT'(k)) ? p_full[ProdWidth-1:0] : '0;
    end
  end

  // NOTE: datapath registers carry no reset: they load only on advance and are
  // never observed unless the matching valid bit is set, which is reset.
  always_ff @(posedge clk_i) begin
    if (adv1) begin
      prod_q   <= prod_d;
      s1_id_q  <= s1_id_d;
      s1_acc_q <= s1_acc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: adder tree and accumulate
  // ---------------------------------------------------------------------------
  TreeT lvl [5][Lanes];
  SumT  sum_q, sum_d;
  IdT   s2_id_q, s2_id_d;

  always_comb begin
    lvl = '{default: '{default: '0}};
    for (int k = 0; k < Lanes; k++) begin
      lvl[0][k] = TreeT'(prod_q[k]);
    end
    // Pairwise reduction: 16 -> 8 -> 4 -> 2 -> 1.
    for (int l = 1; l < 5; l++) begin
      for (int k = 0; k < (Lanes >> l); k++) begin
        lvl[l][k] = lvl[l-1][2*k] + lvl[l-1][2*k+1];
      end
    end
    sum_d   = s1_acc_q + {{(SumWidth-TreeWidth){lvl[4][0][TreeWidth-1]}}, lvl[4][0]};
    s2_id_d = s1_id_q;
  end

  always_ff @(posedge clk_i) begin
    if (adv2) begin
      sum_q   <= sum_d;
      s2_id_q <= s2_id_d;
    end
  end

  // Outputs are masked by the valid bit so an empty or just-reset pipeline
  // presents zeros rather than stale or uninitialised register contents.
  assign out_valid_o = s2_v_q;
  assign out_id_o    = s2_v_q ? s2_id_q : '0;
  assign out_sum_o   = s2_v_q ? sum_q   : '0;

endmodule

// File: tb/tb_xadac_vdot.sv
// -----------------------------------------------------------------------------
// tb_xadac_vdot
//
// Directed bench for xadac_vdot. A reference model computes each expected
// {id, sum} when a bundle is accepted and pushes it to a scoreboard queue; a
// monitor pops and compares whenever a result transfers. Directed steps cover
// reset state, latency, throughput, lane masking, wrap, backpressure and an
// asynchronous reset with operations in flight.
// -----------------------------------------------------------------------------
module tb_xadac_vdot;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_id;
  logic [127:0] in_vs1;
  logic [127:0] in_vs2;
  logic [31:0]  in_acc;
  logic [6:0]   in_vlen;
  logic         in_signed;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_id;
  logic [31:0]  out_sum;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [35:0] sb [$];

  xadac_vdot dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_id_i     (in_id),
    .in_vs1_i    (in_vs1),
    .in_vs2_i    (in_vs2),
    .in_acc_i    (in_acc),
    .in_vlen_i   (in_vlen),
    .in_signed_i (in_signed),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_id_o    (out_id),
    .out_sum_o   (out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [127:0] a, input logic [127:0] b,
                                        input logic [31:0] acc, input logic [6:0] vlen,
                                        input logic sgn);
    longint total;
    int     x, y;
    total = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < int'(vlen)) begin
        x = sgn ? int'($signed(a[8*k +: 8])) : int'(a[8*k +: 8]);
        y = sgn ? int'($signed(b[8*k +: 8])) : int'(b[8*k +: 8]);
        total += longint'(x) * longint'(y);
      end
    end
    total += longint'(acc);
    return total[31:0];
  endfunction

  // Drive one bundle (called just after a rising edge), wait for acceptance
  // within a bounded number of cycles, push the expectation, then drop valid.
  task automatic send(input logic [3:0] id, input logic [127:0] a, input logic [127:0] b,
                      input logic [31:0] acc, input logic [6:0] vlen, input logic sgn,
                      output int waited);
    in_id     = id;
    in_vs1    = a;
    in_vs2    = b;
    in_acc    = acc;
    in_vlen   = vlen;
    in_signed = sgn;
    in_valid  = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (in_ready) sb.push_back({id, model(a, b, acc, vlen, sgn)});
    else          check("send_accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: every result transfer must match the oldest entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", out_valid, 1'b0);
      end else begin
        logic [35:0] exp;
        exp = sb.pop_front();
        check("sb_out_id", out_id, exp[35:32]);
        check("sb_out_sum", out_sum, exp[31:0]);
      end
    end
  end

  initial begin
    int          w;
    logic [31:0] sum1;
    logic [127:0] ra, rb;

    in_valid  = 1'b0;
    in_id     = '0;
    in_vs1    = '0;
    in_vs2    = '0;
    in_acc    = '0;
    in_vlen   = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;

    // Reset state
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_out_id", out_id, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Unsigned all 0xFF, vlen 16, with two-edge latency check
    send(4'h5, {16{8'hFF}}, {16{8'hFF}}, 32'h0, 7'd16, 1'b0, w);
    check("lat_after_accept_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_after_2nd_edge_valid", out_valid, 1'b1);
    check("lat_sum", out_sum, 32'h000FE010);
    check("lat_id", out_id, 4'h5);
    @(posedge clk);
    #1;

    // Back-to-back: signed, lane masking, wrap; each accepted with no wait
    send(4'h6, {16{8'h80}}, {16{8'h7F}}, 32'd5, 7'd16, 1'b1, w);
    check("thru_wait_signed", w, 0);
    send(4'h7, {16{8'h01}}, {16{8'h02}}, 32'h10, 7'd3, 1'b0, w);
    check("thru_wait_vlen3", w, 0);
    send(4'h8, {16{8'h01}}, {16{8'h02}}, 32'h10, 7'd0, 1'b0, w);
    check("thru_wait_vlen0", w, 0);
    send(4'h9, {16{8'h01}}, {16{8'h02}}, 32'h10, 7'd100, 1'b0, w);
    check("thru_wait_vlen100", w, 0);
    send(4'hA, {16{8'hFF}}, {16{8'hFF}}, 32'hFFFFFFFF, 7'd16, 1'b0, w);
    check("thru_wait_wrap", w, 0);

    // Random mix of signedness and lengths, including duplicate ids
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      send(4'(i % 3), ra, rb, $urandom, 7'($urandom_range(0, 20)), 1'($urandom), w);
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_sb_empty", sb.size(), 0);

    // Backpressure: ids 1,2 fill the pipe, id 3 must be held
    out_ready = 1'b0;
    send(4'h1, {16{8'h03}}, {16{8'h04}}, 32'h100, 7'd16, 1'b0, w);
    check("bp_wait_id1", w, 0);
    send(4'h2, {16{8'hFE}}, {16{8'h05}}, 32'h200, 7'd8, 1'b1, w);
    check("bp_wait_id2", w, 0);
    sum1      = model({16{8'h03}}, {16{8'h04}}, 32'h100, 7'd16, 1'b0);
    in_id     = 4'h3;
    in_vs1    = {16{8'h11}};
    in_vs2    = {16{8'h22}};
    in_acc    = 32'h300;
    in_vlen   = 7'd5;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_id", out_id, 4'h1);
      check("bp_hold_sum", out_sum, sum1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_same_cycle", in_ready, 1'b1);
    sb.push_back({4'h3, model({16{8'h11}}, {16{8'h22}}, 32'h300, 7'd5, 1'b0)});
    @(negedge clk);
    check("bp_release_valid_1", out_valid, 1'b1);
    check("bp_release_id_1", out_id, 4'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_release_valid_2", out_valid, 1'b1);
    check("bp_release_id_2", out_id, 4'h2);
    @(negedge clk);
    check("bp_release_valid_3", out_valid, 1'b1);
    check("bp_release_id_3", out_id, 4'h3);
    @(posedge clk);
    #1;
    check("bp_after_empty_valid", out_valid, 1'b0);
    check("bp_sb_empty", sb.size(), 0);

    // Asynchronous reset with two operations in flight
    out_ready = 1'b0;
    send(4'hB, {16{8'h10}}, {16{8'h10}}, 32'h1, 7'd16, 1'b0, w);
    send(4'hC, {16{8'h20}}, {16{8'h20}}, 32'h2, 7'd16, 1'b0, w);
    #3;
    check("mid_pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_sum", out_sum, 32'h0);
    check("mid_rst_out_id", out_id, 4'h0);
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle_valid", out_valid, 1'b0);
    send(4'hD, {16{8'hF6}}, {16{8'h07}}, 32'h1234, 7'd10, 1'b1, w);
    check("post_rst_after_accept_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("post_rst_lat_valid", out_valid, 1'b1);
    check("post_rst_lat_id", out_id, 4'hD);
    check("post_rst_lat_sum", out_sum, 32'h1234 - 32'd700);
    repeat (5) @(posedge clk);
    #1;
    check("final_out_valid", out_valid, 1'b0);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
